// File: rtl/adder_tree_seq_ctrl.sv
// adder_tree_seq_ctrl
//   Sequential accumulation controller. Folds a group of unsigned 8-bit
//   operands into one wide sum, using a single shared 8-bit carry-lookahead
//   adder. The adder works on one byte slice of the accumulator per cycle.
//   This is the low-area alternative to a fully parallel adder tree.
//
// Parameters
//   N_OPS      maximum operands per group (2..256)
//   ACC_BYTES  accumulator width in bytes (1..4); W = 8*ACC_BYTES
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand valid
//   in_ready   controller can accept an operand
//   in_data    unsigned 8-bit operand
//   in_last    final operand of the group (closes the group early)
//   out_valid  group result valid
//   out_ready  downstream accepts the result
//   out_sum    group sum modulo 2^W
//   out_ovf    sticky flag: true group sum reached 2^W
//   out_count  number of operands in the group

// 8-bit carry-lookahead adder. Every carry is expanded into its flat
// generate/propagate form, so there is no ripple chain between bit positions.
module cla_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       pp;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    pp   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin);
    end
    sum  = p ^ c[7:0];
    cout = c[8];
  end

endmodule

module adder_tree_seq_ctrl #(
  parameter int N_OPS     = 8,
  parameter int ACC_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*ACC_BYTES-1:0] out_sum,
  output logic                   out_ovf,
  output logic [8:0]             out_count
);

  localparam int W = 8 * ACC_BYTES;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    ADD    = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [W-1:0] acc;
  logic         carry;
  logic [1:0]   slice;
  logic [8:0]   count;
  logic         ovf;
  logic         last_reg;
  logic [7:0]   op_reg;

  logic [7:0]   cla_a;
  logic [7:0]   cla_b;
  logic         cla_cin;
  logic [7:0]   cla_sum;
  logic         cla_cout;

  logic         last_slice;
  logic [8:0]   count_inc;
  logic         group_end;

  // Operand steering for the shared adder. The new operand enters only at
  // slice 0; higher slices just add the carry from the slice below, so a
  // carry never crosses from one operand into the next.
  always_comb begin
    cla_a = 8'h00;
    for (int i = 0; i < ACC_BYTES; i++) begin
      if (slice == 2'(i)) begin
        cla_a = acc[8*i +: 8];
      end
    end
    cla_b      = (slice == 2'd0) ? op_reg : 8'h00;
    cla_cin    = (slice == 2'd0) ? 1'b0 : carry;
    last_slice = (slice == 2'(ACC_BYTES - 1));
    count_inc  = count + 9'd1;
    group_end  = (count_inc == 9'(N_OPS)) || last_reg;
  end

  cla_8bit u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (cla_cin),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCEPT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode. in_ready and out_valid depend only on
  // the current state, so there is no combinational path from in_valid or
  // out_ready to them.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = ADD;
        end
      end
      ADD: begin
        if (last_slice) begin
          state_next = group_end ? DONE : ACCEPT;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ACCEPT;
        end
      end
      default: begin
        state_next = ACCEPT;
      end
    endcase
  end

  // Datapath registers. The carry out of the top slice only sets the
  // sticky overflow flag; the sum itself wraps modulo 2^W.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      carry    <= 1'b0;
      slice    <= 2'd0;
      count    <= 9'd0;
      ovf      <= 1'b0;
      last_reg <= 1'b0;
      op_reg   <= 8'h00;
    end else begin
      case (state)
        ACCEPT: begin
          if (in_valid) begin
            op_reg   <= in_data;
            last_reg <= in_last;
            slice    <= 2'd0;
          end
        end
        ADD: begin
          for (int i = 0; i < ACC_BYTES; i++) begin
            if (slice == 2'(i)) begin
              acc[8*i +: 8] <= cla_sum;
            end
          end
          carry <= cla_cout;
          if (!last_slice) begin
            slice <= slice + 2'd1;
          end else begin
            ovf   <= ovf | cla_cout;
            count <= count_inc;
          end
        end
        DONE: begin
          if (out_ready) begin
            acc   <= '0;
            ovf   <= 1'b0;
            count <= 9'd0;
            carry <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_sum   = acc;
  assign out_ovf   = ovf;
  assign out_count = count;

endmodule

// File: tb/tb_adder_tree_seq_ctrl.sv
// tb_adder_tree_seq_ctrl
//   Four controller instances with different shapes:
//     dut0  N_OPS=4,   ACC_BYTES=2  (carry chain, early close, stall, reset)
//     dut1  N_OPS=2,   ACC_BYTES=1  (overflow wrap and sticky clear)
//     dut2  N_OPS=256, ACC_BYTES=4  (random groups, wide accumulator)
//     dut3  N_OPS=256, ACC_BYTES=1  (random groups, frequent overflow)
//   Inputs are driven on the falling edge. Expected group results are
//   queued when the closing operand is handed over and popped when the
//   result handshake is seen.
module tb_adder_tree_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        in_valid_v  [4];
  logic [7:0]  in_data_v   [4];
  logic        in_last_v   [4];
  logic        out_ready_v [4];
  logic        in_ready_v  [4];
  logic        out_valid_v [4];
  logic        out_ovf_v   [4];
  logic [8:0]  out_count_v [4];
  logic [31:0] out_sum_v   [4];

  logic [15:0] sum0;
  logic [7:0]  sum1;
  logic [31:0] sum2;
  logic [7:0]  sum3;

  assign out_sum_v[0] = {16'd0, sum0};
  assign out_sum_v[1] = {24'd0, sum1};
  assign out_sum_v[2] = sum2;
  assign out_sum_v[3] = {24'd0, sum3};

  localparam int NOPS [4] = '{4, 2, 256, 256};
  localparam int WID  [4] = '{16, 8, 32, 8};

  adder_tree_seq_ctrl #(.N_OPS(4), .ACC_BYTES(2)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_data(in_data_v[0]), .in_last(in_last_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_sum(sum0), .out_ovf(out_ovf_v[0]), .out_count(out_count_v[0])
  );

  adder_tree_seq_ctrl #(.N_OPS(2), .ACC_BYTES(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_data(in_data_v[1]), .in_last(in_last_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_sum(sum1), .out_ovf(out_ovf_v[1]), .out_count(out_count_v[1])
  );

  adder_tree_seq_ctrl #(.N_OPS(256), .ACC_BYTES(4)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_data(in_data_v[2]), .in_last(in_last_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .out_sum(sum2), .out_ovf(out_ovf_v[2]), .out_count(out_count_v[2])
  );

  adder_tree_seq_ctrl #(.N_OPS(256), .ACC_BYTES(1)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .in_data(in_data_v[3]), .in_last(in_last_v[3]),
    .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]),
    .out_sum(sum3), .out_ovf(out_ovf_v[3]), .out_count(out_count_v[3])
  );

  typedef struct {
    int          dut;
    logic [31:0] sum;
    logic        ovf;
    logic [8:0]  count;
  } exp_t;

  exp_t sb[$];

  logic [63:0] m_sum   [4];
  logic        m_ovf   [4];
  int          m_count [4];

  int total = 0;
  int bad   = 0;
  bit rand_ready = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int d);
    m_sum[d]   = 64'd0;
    m_ovf[d]   = 1'b0;
    m_count[d] = 0;
  endtask

  // Advance to the next falling edge; in random mode the result side of
  // the active instance gets a fresh random ready.
  task automatic tick(input int d);
    @(negedge clk);
    if (rand_ready) out_ready_v[d] = ($urandom_range(0, 2) != 0);
  endtask

  // Offer one operand after an idle gap, wait for acceptance, update the
  // reference model. Returns on the falling edge right after the accept edge.
  task automatic applyStimulus(input int d, input logic [7:0] data, input logic last, input int gap);
    int n;
    logic [63:0] mask;
    exp_t e;
    for (int g = 0; g < gap; g++) tick(d);
    in_valid_v[d] = 1'b1;
    in_data_v[d]  = data;
    in_last_v[d]  = last;
    n = 0;
    while (!in_ready_v[d] && n < 300) begin
      tick(d);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout dut%0d observed=in_ready_low expected=accept", d);
      in_valid_v[d] = 1'b0;
      return;
    end
    tick(d);
    in_valid_v[d] = 1'b0;
    in_last_v[d]  = 1'b0;
    in_data_v[d]  = 8'($urandom);
    mask = (64'd1 << WID[d]) - 64'd1;
    m_sum[d] = m_sum[d] + {56'd0, data};
    if (m_sum[d] > mask) begin
      m_ovf[d] = 1'b1;
      m_sum[d] = m_sum[d] & mask;
    end
    m_count[d]++;
    if (last || m_count[d] == NOPS[d]) begin
      e.dut   = d;
      e.sum   = 32'(m_sum[d]);
      e.ovf   = m_ovf[d];
      e.count = 9'(m_count[d]);
      sb.push_back(e);
      model_clear(d);
    end
  endtask

  // Result monitor: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    #1;
    for (int d = 0; d < 4; d++) begin
      if (out_valid_v[d] && out_ready_v[d] && !rst) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_result dut%0d observed=sum_%0h expected=none", d, out_sum_v[d]);
        end else begin
          e = sb.pop_front();
          checkOutput($sformatf("dut%0d_id", d), 32'(d), 32'(e.dut));
          checkOutput($sformatf("dut%0d_sum", d), out_sum_v[d], e.sum);
          checkOutput($sformatf("dut%0d_ovf", d), 32'(out_ovf_v[d]), 32'(e.ovf));
          checkOutput($sformatf("dut%0d_count", d), 32'(out_count_v[d]), 32'(e.count));
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready_v[0]), 32'd1);
    checkOutput({tag, "_out_valid"}, 32'(out_valid_v[0]), 32'd0);
    checkOutput({tag, "_out_sum"}, out_sum_v[0], 32'd0);
    checkOutput({tag, "_out_ovf"}, 32'(out_ovf_v[0]), 32'd0);
    checkOutput({tag, "_out_count"}, 32'(out_count_v[0]), 32'd0);
  endtask

  initial begin
    int n;
    int len;
    rst = 1'b1;
    for (int d = 0; d < 4; d++) begin
      in_valid_v[d]  = 1'b0;
      in_data_v[d]   = 8'h00;
      in_last_v[d]   = 1'b0;
      out_ready_v[d] = 1'b0;
      model_clear(d);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    // Carry propagation through both slices, plus per-operand cadence.
    out_ready_v[0] = 1'b1;
    applyStimulus(0, 8'hFF, 1'b0, 0);
    checkOutput("cadence_c0", 32'(in_ready_v[0]), 32'd0);
    tick(0);
    checkOutput("cadence_c1", 32'(in_ready_v[0]), 32'd0);
    tick(0);
    checkOutput("cadence_c2", 32'(in_ready_v[0]), 32'd1);
    applyStimulus(0, 8'hFF, 1'b0, 0);
    applyStimulus(0, 8'hFF, 1'b0, 0);
    applyStimulus(0, 8'hFF, 1'b0, 0);
    checkOutput("ovalid_c0", 32'(out_valid_v[0]), 32'd0);
    tick(0);
    checkOutput("ovalid_c1", 32'(out_valid_v[0]), 32'd0);
    tick(0);
    checkOutput("ovalid_c2", 32'(out_valid_v[0]), 32'd1);
    checkOutput("carry_sum", out_sum_v[0], 32'h0000_03FC);

    // Early close, fresh accumulator, one-operand group, last at the limit.
    applyStimulus(0, 8'h10, 1'b0, 1);
    applyStimulus(0, 8'h22, 1'b1, 0);
    applyStimulus(0, 8'h05, 1'b1, 2);
    applyStimulus(0, 8'h81, 1'b0, 0);
    applyStimulus(0, 8'h82, 1'b0, 1);
    applyStimulus(0, 8'h83, 1'b0, 0);
    applyStimulus(0, 8'h84, 1'b1, 0);

    // Overflow wrap and sticky clear on the 8-bit accumulator.
    out_ready_v[1] = 1'b1;
    applyStimulus(1, 8'd200, 1'b0, 0);
    applyStimulus(1, 8'd100, 1'b0, 0);
    applyStimulus(1, 8'd3, 1'b0, 1);
    applyStimulus(1, 8'd4, 1'b0, 0);

    // Backpressure: result held stable, inputs ignored during the stall.
    applyStimulus(0, 8'h00, 1'b0, 4);
    out_ready_v[0] = 1'b0;
    tick(0);
    tick(0);
    applyStimulus(0, 8'h33, 1'b0, 0);
    applyStimulus(0, 8'h40, 1'b1, 0);
    n = 0;
    while (!out_valid_v[0] && n < 20) begin
      tick(0);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("[TB] FAIL stall_wait observed=out_valid_low expected=out_valid_high");
    end
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("stall%0d_valid", k), 32'(out_valid_v[0]), 32'd1);
      checkOutput($sformatf("stall%0d_sum", k), out_sum_v[0], 32'h0000_0073);
      checkOutput($sformatf("stall%0d_count", k), 32'(out_count_v[0]), 32'd3);
      checkOutput($sformatf("stall%0d_in_ready", k), 32'(in_ready_v[0]), 32'd0);
      in_valid_v[0] = k[0];
      in_data_v[0]  = 8'($urandom);
      in_last_v[0]  = 1'b1;
      tick(0);
    end
    in_valid_v[0]  = 1'b0;
    in_last_v[0]   = 1'b0;
    out_ready_v[0] = 1'b1;
    tick(0);
    checkOutput("release_in_ready", 32'(in_ready_v[0]), 32'd1);
    checkOutput("release_out_valid", 32'(out_valid_v[0]), 32'd0);

    // Reset during the slice-1 add of the third operand abandons the group.
    applyStimulus(0, 8'h01, 1'b0, 0);
    applyStimulus(0, 8'h02, 1'b0, 0);
    applyStimulus(0, 8'h03, 1'b0, 0);
    tick(0);
    rst = 1'b1;
    tick(0);
    rst = 1'b0;
    model_clear(0);
    check_reset_state("midreset");
    applyStimulus(0, 8'h01, 1'b0, 0);
    applyStimulus(0, 8'h01, 1'b1, 0);

    // Randomized groups with random gaps and random result backpressure.
    rand_ready = 1'b1;
    for (int k = 0; k < 256; k++) applyStimulus(3, 8'($urandom), 1'b0, 0);
    for (int g = 0; g < 600; g++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++)
        applyStimulus(3, 8'($urandom), (k == len - 1), $urandom_range(0, 2));
    end
    for (int k = 0; k < 256; k++) applyStimulus(2, 8'($urandom_range(128, 255)), 1'b0, 0);
    for (int g = 0; g < 400; g++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++)
        applyStimulus(2, 8'($urandom), (k == len - 1), $urandom_range(0, 2));
    end

    // Drain every pending result.
    rand_ready = 1'b0;
    for (int d = 0; d < 4; d++) out_ready_v[d] = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain observed=%0d_pending expected=0_pending", sb.size());
    end
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_tree_seq_ctrl.md
Name: adder_tree_seq_ctrl

Overview:
- Sequential accumulation controller that reduces a group of 8-bit operands into one wide sum using a single shared cla_8bit instance, processed one byte slice per cycle.
- Sits in the adder_tree_8bit flow as the low-area alternative to a fully parallel tree.
- Inputs and outputs are valid/ready streams.
- The controller sequences the CLA's a, b and cin inputs and captures its sum and cout.

Parameters:
- N_OPS, 8: maximum operands per group; legal range 2..256.
- ACC_BYTES, 2: accumulator width in bytes; legal range 1..4. Accumulator width W = 8*ACC_BYTES.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand valid.
- in_ready  out  1  controller can accept an operand.
- in_data  in  8  unsigned operand.
- in_last  in  1  final operand of the group; sampled with in_data and closes the group early.
- out_valid  out  1  group result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  W  group sum modulo 2^W.
- out_ovf  out  1  sticky flag: the true group sum was at least 2^W.
- out_count  out  9  number of operands in the group (1..N_OPS).

Behaviour:
- Reset: state=ACCEPT, acc=0, carry=0, slice=0, count=0, ovf=0, last_reg=0, op_reg=0. Outputs after reset: in_ready=1, out_valid=0, out_sum=0, out_ovf=0, out_count=0.
- Reset has priority over every other event. Asserting rst mid-operation abandons the group. No partial result is emitted.
- Datapath uses one cla_8bit only. Operand b is op_reg at slice 0 and 0x00 at higher slices. cin is 0 at slice 0 and carry otherwise. Operand a is acc[8*slice +: 8].
- ACCEPT state:
  - in_ready=1 and out_valid=0.
  - On in_valid: op_reg<=in_data, last_reg<=in_last, slice<=0, then go to ADD.
- ADD state (in_ready=0). Each cycle:
  - acc[slice]<=cla sum and carry<=cla cout.
  - If slice<ACC_BYTES-1: slice<=slice+1.
  - At the last slice:
    - ovf<=ovf | cout and count<=count+1.
    - If count+1==N_OPS or last_reg=1, go to DONE; otherwise go to ACCEPT.
- DONE state:
  - out_valid=1 and in_ready=0.
  - out_sum=acc, out_ovf=ovf, out_count=count; all held stable while out_valid && !out_ready.
  - On out_ready: clear acc, ovf, count and carry, then go to ACCEPT.
- Latency and throughput:
  - One operand costs 1+ACC_BYTES cycles, from the accept edge to the next in_ready=1.
  - out_valid rises on the cycle after the final slice of the last operand.
  - Peak throughput is one operand per 1+ACC_BYTES cycles.
- Carry chaining:
  - The carry produced at slice k feeds cin at slice k+1 of the same operand only.
  - The carry out of the top slice wraps (sum modulo 2^W) and only sets ovf. It never carries into the next operand.
- Boundary conditions:
  - in_last on the first operand gives a one-operand group: out_count=1.
  - in_last on operand N_OPS is equivalent to reaching the count limit.
  - in_data and in_last are ignored while in_ready=0.
  - out_ready asserted outside DONE has no effect.
  - A zero-operand group is not possible.
- No combinational path from in_valid or out_ready to in_ready or out_valid. Both are decoded from state only.

Test Plan:
- Carry propagation (N_OPS=4, ACC_BYTES=2): operands 0xFF, 0xFF, 0xFF, 0xFF with out_ready=1 -> out_sum=0x03FC, out_ovf=0, out_count=4. Each operand takes 3 cycles; out_valid is asserted exactly 1 cycle after the 4th ADD completes.
- Early close (N_OPS=8, ACC_BYTES=2): operands 0x10 then 0x22 with in_last=1 -> out_sum=0x0032, out_count=2. The next group starts from acc=0: a single operand 0x05 with in_last=1 -> out_sum=0x0005.
- Overflow wrap (N_OPS=2, ACC_BYTES=1): operands 200, 100 -> out_sum=0x2C, out_ovf=1. The next group (3, 4) -> out_sum=0x07, out_ovf=0, confirming the sticky flag clears per group.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid, out_sum and out_count are stable and in_ready=0 throughout. Toggling in_valid during the stall changes nothing. Releasing out_ready -> in_ready=1 on the next cycle.
- Reset mid-operation (ACC_BYTES=2): rst=1 during the slice-1 ADD cycle of the 3rd operand -> next cycle all outputs are at reset values. A following group 0x01, 0x01 with in_last=1 -> out_sum=0x0002.
- Randomized check (N_OPS=256, ACC_BYTES=1 and ACC_BYTES=4): compare against a reference model summing modulo 2^W with an overflow flag. Run 1000 groups with random valid and ready gaps.
